vram_write_sched: RTL and testbench

VRAM_WRITE_SCHED -- requirements
Module: vram_write_sched

---
 rtl/vram_write_sched.sv | 86 ++++++++
 tb/tb_vram_write_sched.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vram_write_sched.sv
// vram_write_sched: arbitrates CPU byte writes and region fills into one registered VRAM write port
module vram_write_sched #(
  parameter int ADDR_WIDTH = 12,
  parameter int VRAM_SIZE  = 2304
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  writable,
  input  logic                  cpu_valid,
  output logic                  cpu_ready,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]            cpu_data,
  input  logic                  fill_start,
  input  logic [ADDR_WIDTH-1:0] fill_base,
  input  logic [ADDR_WIDTH:0]   fill_len,
  input  logic [7:0]            fill_value,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  fill_err,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  output logic [7:0]            vram_data,
  output logic                  vram_we
);
  localparam logic [ADDR_WIDTH:0]   SIZE = (ADDR_WIDTH+1)'(VRAM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(VRAM_SIZE - 1);
  localparam logic [ADDR_WIDTH:0]   ONE  = (ADDR_WIDTH+1)'(1);
  typedef enum logic {IDLE, FILL} state_t;
  state_t                state;
  logic [ADDR_WIDTH-1:0] cursor;
  logic [ADDR_WIDTH:0]   remaining;
  logic [7:0]            value;
  logic                  hs;
  logic                  cpu_wr;
  logic                  fill_wr;
  // A handshake always consumes the write slot, even when its address is out of range and the byte is dropped
  assign cpu_ready = writable;
  assign hs        = cpu_valid && writable;
  assign cpu_wr    = hs && ({1'b0, cpu_addr} < SIZE);
  assign fill_wr   = (state == FILL) && writable && !hs;
  assign fill_busy = state == FILL;
  // Issue at most one registered write per cycle and run the fill FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cursor    <= '0;
      remaining <= '0;
      value     <= '0;
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_data <= '0;
      fill_done <= 1'b0;
      fill_err  <= 1'b0;
    end else begin
      vram_we   <= 1'b0;
      fill_done <= 1'b0;
      fill_err  <= 1'b0;
      if (cpu_wr) begin
        vram_we   <= 1'b1;
        vram_addr <= cpu_addr;
        vram_data <= cpu_data;
      end else if (fill_wr) begin
        vram_we   <= 1'b1;
        vram_addr <= cursor;
        vram_data <= value;
        cursor    <= (cursor == LAST) ? '0 : cursor + 1'b1;
        remaining <= remaining - ONE;
        if (remaining == ONE) begin
          state     <= IDLE;
          fill_done <= 1'b1;
        end
      end
      if (state == IDLE && fill_start) begin
        if ({1'b0, fill_base} >= SIZE)
          fill_err <= 1'b1;
        else if (fill_len == '0)
          fill_done <= 1'b1;
        else begin
          state     <= FILL;
          cursor    <= fill_base;
          remaining <= (fill_len > SIZE) ? SIZE : fill_len;
          value     <= fill_value;
        end
      end
    end
  end
endmodule

// File: tb/tb_vram_write_sched.sv
// tb_vram_write_sched: directed self-checking bench for vram_write_sched
module tb_vram_write_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        writable = 1'b0;
  logic        cpu_valid = 1'b0;
  logic        cpu_ready;
  logic [11:0] cpu_addr = '0;
  logic [7:0]  cpu_data = '0;
  logic        fill_start = 1'b0;
  logic [11:0] fill_base = '0;
  logic [12:0] fill_len = '0;
  logic [7:0]  fill_value = '0;
  logic        fill_busy, fill_done, fill_err, vram_we;
  logic [11:0] vram_addr;
  logic [7:0]  vram_data;

  int n_assert = 0;
  int n_fail = 0;
  int n_wr = 0;
  int n_cpu = 0;
  logic        m_busy = 1'b0;
  logic [11:0] m_cur = '0;
  int          m_rem = 0;
  logic [7:0]  m_val = '0;
  logic [11:0] e_addr = '0;
  logic [7:0]  e_data = '0;

  vram_write_sched #(.ADDR_WIDTH(12), .VRAM_SIZE(2304)) dut (
    .clk(clk), .rst(rst), .writable(writable),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len), .fill_value(fill_value),
    .fill_busy(fill_busy), .fill_done(fill_done), .fill_err(fill_err),
    .vram_addr(vram_addr), .vram_data(vram_data), .vram_we(vram_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given CPU inputs; expected outputs come from a behavioural model of the scheduler
  task automatic step(input logic wr, input logic cv, input logic [11:0] ca, input logic [7:0] cd);
    logic b0, hs, e_we, e_done, e_err;
    writable = wr; cpu_valid = cv; cpu_addr = ca; cpu_data = cd;
    @(posedge clk); #1;
    b0 = m_busy; hs = cv && wr; e_we = 0; e_done = 0; e_err = 0;
    if (hs && ca < 12'd2304) begin
      e_we = 1; e_addr = ca; e_data = cd;
    end else if (m_busy && wr && !hs) begin
      e_we = 1; e_addr = m_cur; e_data = m_val;
      m_cur = (m_cur == 12'd2303) ? 12'd0 : m_cur + 12'd1;
      m_rem--;
      if (m_rem == 0) begin m_busy = 0; e_done = 1; end
    end
    if (!b0 && fill_start) begin
      if (fill_base >= 12'd2304) e_err = 1;
      else if (fill_len == 0) e_done = 1;
      else begin
        m_busy = 1; m_cur = fill_base; m_val = fill_value;
        m_rem = (fill_len > 13'd2304) ? 2304 : int'(fill_len);
      end
    end
    if (hs && ca < 12'd2304) n_cpu++;
    chk("we", vram_we, e_we);
    chk("addr", vram_addr, e_addr);
    chk("data", vram_data, e_data);
    chk("done", fill_done, e_done);
    chk("err", fill_err, e_err);
    chk("busy", fill_busy, m_busy);
    if (vram_we) n_wr++;
    fill_start = 0;
  endtask

  task automatic req_fill(input logic [11:0] b, input logic [12:0] l, input logic [7:0] v);
    fill_base = b; fill_len = l; fill_value = v; fill_start = 1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", vram_we, 0);
    chk("rst_addr", vram_addr, 0);
    chk("rst_data", vram_data, 0);
    chk("rst_busy", fill_busy, 0);
    chk("rst_done", fill_done, 0);
    chk("rst_err", fill_err, 0);
    chk("ready_lo", cpu_ready, 0);
    writable = 1; #1;
    chk("ready_hi", cpu_ready, 1);
    rst = 0;
    step(1, 1, 12'h400, 8'h2a);
    chk("cpu_addr_400", vram_addr, 12'h400);
    step(1, 1, 12'h900, 8'h55);
    chk("cpu_drop_900", vram_we, 0);
    step(0, 1, 12'h123, 8'h11);
    step(1, 0, 12'h0, 8'h0);
    n_wr = 0;
    req_fill(12'h800, 13'd256, 8'hff);
    step(1, 0, 12'h0, 8'h0);
    for (int i = 0; i < 256; i++) step(1, 0, 12'h0, 8'h0);
    chk("f256_count", n_wr, 256);
    chk("f256_last", vram_addr, 12'h8ff);
    step(1, 0, 12'h0, 8'h0);
    chk("f256_idle", fill_busy, 0);
    n_wr = 0;
    req_fill(12'h8fe, 13'd4, 8'h3c);
    step(1, 0, 12'h0, 8'h0);
    for (int i = 0; i < 4; i++) step(1, 0, 12'h0, 8'h0);
    chk("wrap_count", n_wr, 4);
    chk("wrap_last", vram_addr, 12'h001);
    n_wr = 0; n_cpu = 0;
    req_fill(12'h100, 13'd16, 8'ha5);
    step(1, 0, 12'h0, 8'h0);
    for (int c = 0; c < 50; c++)
      step(((c / 3) % 2) == 0, (c % 4) == 1, 12'h200 + 12'(c), 8'(c));
    chk("mix_cpu", n_cpu, 5);
    chk("mix_count", n_wr, 21);
    chk("mix_idle", fill_busy, 0);
    n_wr = 0;
    req_fill(12'h010, 13'd0, 8'h01);
    step(1, 0, 12'h0, 8'h0);
    chk("len0_done", fill_done, 1);
    req_fill(12'h900, 13'd8, 8'h01);
    step(1, 0, 12'h0, 8'h0);
    chk("base_err", fill_err, 1);
    step(1, 0, 12'h0, 8'h0);
    chk("bad_nowr", n_wr, 0);
    req_fill(12'h010, 13'd4000, 8'h77);
    step(1, 0, 12'h0, 8'h0);
    step(1, 0, 12'h0, 8'h0);
    req_fill(12'h900, 13'd8, 8'h01);
    step(1, 0, 12'h0, 8'h0);
    for (int i = 0; i < 2302; i++) step(1, 0, 12'h0, 8'h0);
    chk("clamp_count", n_wr, 2304);
    chk("clamp_last", vram_addr, 12'h00f);
    step(1, 0, 12'h0, 8'h0);
    chk("clamp_idle", fill_busy, 0);
    n_wr = 0; n_cpu = 0;
    req_fill(12'h300, 13'd40, 8'h99);
    step(1, 1, 12'h050, 8'h77);
    chk("sim_cpu_first", vram_addr, 12'h050);
    for (int i = 0; i < 10; i++) step(1, 0, 12'h0, 8'h0);
    chk("pre_rst_count", n_wr, 11);
    rst = 1; #1;
    chk("arst_we", vram_we, 0);
    chk("arst_busy", fill_busy, 0);
    chk("arst_addr", vram_addr, 0);
    @(posedge clk); #1;
    chk("arst_done", fill_done, 0);
    rst = 0;
    m_busy = 0; m_rem = 0; m_cur = '0; e_addr = '0; e_data = '0;
    n_wr = 0;
    req_fill(12'h020, 13'd5, 8'h5a);
    step(1, 0, 12'h0, 8'h0);
    for (int i = 0; i < 5; i++) step(1, 0, 12'h0, 8'h0);
    chk("post_rst_count", n_wr, 5);
    chk("post_rst_last", vram_addr, 12'h024);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
